// File: rtl/robot_motion_if.sv
// ---------------------------------------------------------------------------
// robot_motion_if
// Bundles the world-side sensor strobe inputs and the robot pose/status
// outputs of the motion controller.
//   master : world / environment side (drives tick and sensors, observes pose)
//   slave  : controller side
// Signals:
//   tick              step strobe, one cycle wide
//   head_wall         wall in the cell ahead
//   left_wall         wall in the cell to the left
//   head_trash        trash in the cell ahead
//   robot_row[5:0]    current row, 1-based (1..10)
//   robot_column[5:0] current column, 1-based (1..20)
//   robot_orientation N=00 S=01 E=10 W=11
//   moved             pulse after each forward step
//   cleaning          high while removing trash
//   trash_cleared     pulse when a trash item is gone
// ---------------------------------------------------------------------------
interface robot_motion_if;
    logic       tick;
    logic       head_wall;
    logic       left_wall;
    logic       head_trash;
    logic [5:0] robot_row;
    logic [5:0] robot_column;
    logic [1:0] robot_orientation;
    logic       moved;
    logic       cleaning;
    logic       trash_cleared;

    modport master (
        output tick, head_wall, left_wall, head_trash,
        input  robot_row, robot_column, robot_orientation,
               moved, cleaning, trash_cleared
    );

    modport slave (
        input  tick, head_wall, left_wall, head_trash,
        output robot_row, robot_column, robot_orientation,
               moved, cleaning, trash_cleared
    );
endinterface

// File: rtl/robot_motion_ctrl.sv
// ---------------------------------------------------------------------------
// robot_motion_ctrl
// Left-hand wall-following cleaning robot on a 10 x 20 grid. On every tick
// the robot either starts cleaning the trash ahead, turns left (at most once
// in a row), steps forward, or turns right. Cleaning occupies CLEAN_TICKS
// ticks in total and ends with a trash_cleared pulse.
// Ports:
//   clock : system clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : robot_motion_if.slave (sensors in, pose/status out)
// All outputs are registered; decisions taken on the tick edge are visible
// in the following cycle.
// ---------------------------------------------------------------------------
module robot_motion_ctrl #(
    parameter logic [5:0]  START_ROW    = 6'd10,
    parameter logic [5:0]  START_COL    = 6'd1,
    parameter logic [1:0]  START_ORIENT = 2'b00,
    parameter int unsigned CLEAN_TICKS  = 4
) (
    input  logic          clock,
    input  logic          reset,
    robot_motion_if.slave bus
);

    localparam logic [1:0] DIR_N = 2'b00;
    localparam logic [1:0] DIR_S = 2'b01;
    localparam logic [1:0] DIR_E = 2'b10;
    localparam logic [1:0] DIR_W = 2'b11;

    localparam logic [5:0] ROW_MIN = 6'd1;
    localparam logic [5:0] ROW_MAX = 6'd10;
    localparam logic [5:0] COL_MIN = 6'd1;
    localparam logic [5:0] COL_MAX = 6'd20;

    localparam logic [3:0] CNT_LOAD = 4'(CLEAN_TICKS - 1);

    typedef enum logic [0:0] {
        ST_DECIDE = 1'b0,
        ST_CLEAN  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       turned_left_q, turned_left_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] row_q, row_d;
    logic [5:0] col_q, col_d;
    logic [1:0] orient_q, orient_d;
    logic       moved_q, moved_d;
    logic       cleaning_q, cleaning_d;
    logic       cleared_q, cleared_d;

    logic       ahead_open_s;
    logic       left_open_s;

    // Counter-clockwise quarter turn: N->W->S->E->N.
    function automatic logic [1:0] rot_left(input logic [1:0] dir);
        logic [1:0] r;
        case (dir)
            DIR_N:   r = DIR_W;
            DIR_W:   r = DIR_S;
            DIR_S:   r = DIR_E;
            DIR_E:   r = DIR_N;
            default: r = DIR_N;
        endcase
        return r;
    endfunction

    // Clockwise quarter turn: N->E->S->W->N.
    function automatic logic [1:0] rot_right(input logic [1:0] dir);
        logic [1:0] r;
        case (dir)
            DIR_N:   r = DIR_E;
            DIR_E:   r = DIR_S;
            DIR_S:   r = DIR_W;
            DIR_W:   r = DIR_N;
            default: r = DIR_N;
        endcase
        return r;
    endfunction

    // True when the neighbour cell in direction dir lies outside the grid.
    function automatic logic off_grid(input logic [1:0] dir,
                                      input logic [5:0] row,
                                      input logic [5:0] col);
        logic r;
        case (dir)
            DIR_N:   r = (row == ROW_MIN);
            DIR_S:   r = (row == ROW_MAX);
            DIR_E:   r = (col == COL_MAX);
            DIR_W:   r = (col == COL_MIN);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // The grid border counts as a wall whatever the sensors report.
    assign ahead_open_s = !bus.head_wall && !off_grid(orient_q, row_q, col_q);
    assign left_open_s  = !bus.left_wall && !off_grid(rot_left(orient_q), row_q, col_q);

    // Next-state decision, evaluated only on tick cycles.
    always_comb begin
        state_d       = state_q;
        turned_left_d = turned_left_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        orient_d      = orient_q;
        moved_d       = 1'b0;
        cleared_d     = 1'b0;

        if (bus.tick) begin
            case (state_q)
                ST_DECIDE: begin
                    if (ahead_open_s && bus.head_trash) begin
                        state_d = ST_CLEAN;
                        cnt_d   = CNT_LOAD;
                    end else if (left_open_s && !turned_left_q) begin
                        orient_d      = rot_left(orient_q);
                        turned_left_d = 1'b1;
                    end else if (ahead_open_s) begin
                        // Only reached when the target cell is inside the grid.
                        case (orient_q)
                            DIR_N:   row_d = row_q - 6'd1;
                            DIR_S:   row_d = row_q + 6'd1;
                            DIR_E:   col_d = col_q + 6'd1;
                            DIR_W:   col_d = col_q - 6'd1;
                            default: row_d = row_q;
                        endcase
                        moved_d       = 1'b1;
                        turned_left_d = 1'b0;
                    end else begin
                        orient_d      = rot_right(orient_q);
                        turned_left_d = 1'b0;
                    end
                end
                ST_CLEAN: begin
                    // Sensors are ignored; turned_left survives the cleaning.
                    if (cnt_q == 4'd0) begin
                        state_d   = ST_DECIDE;
                        cleared_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_DECIDE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        cleaning_d = (state_d == ST_CLEAN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_DECIDE;
            turned_left_q <= 1'b0;
            cnt_q         <= 4'd0;
            row_q         <= START_ROW;
            col_q         <= START_COL;
            orient_q      <= START_ORIENT;
            moved_q       <= 1'b0;
            cleaning_q    <= 1'b0;
            cleared_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            turned_left_q <= turned_left_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            orient_q      <= orient_d;
            moved_q       <= moved_d;
            cleaning_q    <= cleaning_d;
            cleared_q     <= cleared_d;
        end
    end

    assign bus.robot_row         = row_q;
    assign bus.robot_column      = col_q;
    assign bus.robot_orientation = orient_q;
    assign bus.moved             = moved_q;
    assign bus.cleaning          = cleaning_q;
    assign bus.trash_cleared     = cleared_q;

endmodule

// File: tb/tb_robot_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_robot_motion_ctrl
// Directed and random stimulus for robot_motion_ctrl. A compass-angle model
// of the robot (heading in degrees, grid bounds checked on the neighbour
// coordinates) predicts every output each cycle; literal expectations pin
// the model at key points of the directed sequence.
// ---------------------------------------------------------------------------
module tb_robot_motion_ctrl;

    localparam int CT = 4;

    logic clk = 1'b0;
    logic rst;

    robot_motion_if bus();

    robot_motion_ctrl #(
        .START_ROW   (6'd10),
        .START_COL   (6'd1),
        .START_ORIENT(2'b00),
        .CLEAN_TICKS (CT)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int moved_seen = 0;
    int clr_seen   = 0;

    // model state
    int m_row, m_col, m_head, m_cnt;
    bit m_tl, m_clean, e_moved, e_clr;

    function automatic int dr(input int h);
        if (h == 0)   return -1;
        if (h == 180) return 1;
        return 0;
    endfunction

    function automatic int dc(input int h);
        if (h == 90)  return 1;
        if (h == 270) return -1;
        return 0;
    endfunction

    function automatic bit in_grid(input int r, input int c);
        return (r >= 1) && (r <= 10) && (c >= 1) && (c <= 20);
    endfunction

    function automatic int enc(input int h);
        if (h == 0)   return 0;
        if (h == 180) return 1;
        if (h == 90)  return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_row = 10; m_col = 1; m_head = 0; m_cnt = 0;
        m_tl = 1'b0; m_clean = 1'b0; e_moved = 1'b0; e_clr = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit hw, input bit lw, input bit ht);
        bit ahead_ok, left_ok;
        int lh;
        e_moved = 1'b0;
        e_clr   = 1'b0;
        if (t) begin
            if (m_clean) begin
                if (m_cnt == 0) begin
                    m_clean = 1'b0;
                    e_clr   = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                lh       = (m_head + 270) % 360;
                ahead_ok = !hw && in_grid(m_row + dr(m_head), m_col + dc(m_head));
                left_ok  = !lw && in_grid(m_row + dr(lh), m_col + dc(lh));
                if (ahead_ok && ht) begin
                    m_clean = 1'b1;
                    m_cnt   = CT - 1;
                end else if (left_ok && !m_tl) begin
                    m_head = lh;
                    m_tl   = 1'b1;
                end else if (ahead_ok) begin
                    m_row   = m_row + dr(m_head);
                    m_col   = m_col + dc(m_head);
                    e_moved = 1'b1;
                    m_tl    = 1'b0;
                end else begin
                    m_head = (m_head + 90) % 360;
                    m_tl   = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare_all();
        int g_row, g_col, g_or;
        g_row = int'(bus.robot_row);
        g_col = int'(bus.robot_column);
        g_or  = int'(bus.robot_orientation);
        n_tests++;
        if (g_row != m_row || g_col != m_col || g_or != enc(m_head) ||
            bus.moved != e_moved || bus.cleaning != m_clean || bus.trash_cleared != e_clr) begin
            n_fail++;
            $display("FAIL model t=%0t: got r=%0d c=%0d o=%0d mv=%0b cl=%0b tc=%0b expected r=%0d c=%0d o=%0d mv=%0b cl=%0b tc=%0b",
                     $time, g_row, g_col, g_or, bus.moved, bus.cleaning, bus.trash_cleared,
                     m_row, m_col, enc(m_head), e_moved, m_clean, e_clr);
        end
        n_tests++;
        if (g_row < 1 || g_row > 10 || g_col < 1 || g_col > 20) begin
            n_fail++;
            $display("FAIL range: got r=%0d c=%0d required r in 1..10 c in 1..20", g_row, g_col);
        end
        n_tests++;
        if (bus.moved && bus.trash_cleared) begin
            n_fail++;
            $display("FAIL pulse_excl: got moved=1 trash_cleared=1 required not both");
        end
        if (bus.moved)         moved_seen++;
        if (bus.trash_cleared) clr_seen++;
    endtask

    // One clock: drive at negedge, model follows the rising edge, compare at next negedge.
    task automatic cycle(input bit t, input bit hw, input bit lw, input bit ht);
        bus.tick       = t;
        bus.head_wall  = hw;
        bus.left_wall  = lw;
        bus.head_trash = ht;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(t, hw, lw, ht);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int ticks;
        int mv0, cl0;
        bit t, hw, lw, ht;

        rst = 1'b1;
        bus.tick = 1'b0; bus.head_wall = 1'b0; bus.left_wall = 1'b0; bus.head_trash = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_row",    int'(bus.robot_row), 10);
        check("rst_col",    int'(bus.robot_column), 1);
        check("rst_orient", int'(bus.robot_orientation), 0);
        check("rst_flags",  int'({bus.moved, bus.cleaning, bus.trash_cleared}), 0);

        // tick while reset is still asserted must be ignored
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("tick_in_rst_row", int'(bus.robot_row), 10);
        rst = 1'b0;

        // three forward steps north along the west border
        mv0 = moved_seen;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("fwd3_row",   int'(bus.robot_row), 7);
        check("fwd3_col",   int'(bus.robot_column), 1);
        check("fwd3_moved", moved_seen - mv0, 3);

        // left sensor clear but west of column 1 is off-grid: step forward
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("edge_left_row",    int'(bus.robot_row), 6);
        check("edge_left_orient", int'(bus.robot_orientation), 0);

        // everything walled: turn right to east
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("turn_right", int'(bus.robot_orientation), 2);
        // no tick: nothing changes
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_orient", int'(bus.robot_orientation), 2);

        // east to column 2, then left turn, then forced forward because turned_left
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("east_col", int'(bus.robot_column), 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("turn_left", int'(bus.robot_orientation), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("tl_fwd_row", int'(bus.robot_row), 5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("turn_left_w", int'(bus.robot_orientation), 3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("tl_right_n", int'(bus.robot_orientation), 0);

        // trash ahead but wall ahead: no cleaning, turn right
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("trash_walled_cl", int'(bus.cleaning), 0);
        check("trash_walled_or", int'(bus.robot_orientation), 2);

        // full cleaning cycle, non-tick gaps in between
        cl0 = clr_seen;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("clean_enter", int'(bus.cleaning), 1);
        for (int k = 1; k <= CT; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
            check("clean_tc", int'(bus.trash_cleared), (k == CT) ? 1 : 0);
            check("clean_cl", int'(bus.cleaning), (k == CT) ? 0 : 1);
        end
        check("clean_pulses", clr_seen - cl0, 1);
        check("clean_pos", int'({bus.robot_row, bus.robot_column}), (5 << 6) | 2);

        // reset in the middle of cleaning
        cl0 = clr_seen;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_clean", int'(bus.cleaning), 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("abort_row",   int'(bus.robot_row), 10);
        check("abort_col",   int'(bus.robot_column), 1);
        check("abort_flags", int'({bus.moved, bus.cleaning, bus.trash_cleared}), 0);
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_no_clr", clr_seen - cl0, 0);

        // random sensors, mix of back-to-back and spaced ticks
        ticks = 0;
        while (ticks < 1000) begin
            t  = ($urandom_range(0, 3) != 0);
            hw = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            ht = ($urandom_range(0, 3) == 0);
            cycle(t, hw, lw, ht);
            if (t) ticks++;
        end
        bus.tick = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
